// File: rtl/dmem_wait_resp_if.sv
// MEM-stage data port bundle between the pipeline (master) and the
// multi-cycle data memory responder (slave).
interface dmem_wait_resp_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ack, err, stall
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ack, err, stall
    );
endinterface

// File: rtl/dmem_wait_resp.sv
// Data memory with a fixed access latency: accepts one request, stalls the
// pipeline for LATENCY busy cycles, then performs the access and acks once.
module dmem_wait_resp #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    dmem_wait_resp_if.slave  bus
);
    localparam int          IW       = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         r_state, w_state_nxt;
    logic [3:0]     r_cnt;
    logic           r_we;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [3:0]     r_be;
    logic [31:0]    r_rdata;
    logic           r_ack;
    logic           r_err;
    logic [31:0]    r_mem [DEPTH];

    logic           w_access;
    logic           w_bad;
    logic [IW-1:0]  w_idx;

    assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);
    assign w_bad    = (r_addr[1:0] != 2'b00) || (r_addr[31:2] >= DEPTH_W);
    assign w_idx    = r_addr[IW+1:2];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.req) w_state_nxt = BUSY;
            BUSY:    if (r_cnt == 4'd0) w_state_nxt = DONE;
            // The pipeline still presents the completing request here, so never accept.
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: if (bus.req) r_cnt <= CNT_INIT;
                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_ack   <= 1'b1;
                        r_err   <= w_bad;
                        r_rdata <= (w_bad || r_we) ? 32'd0 : r_mem[w_idx];
                    end
                end
                DONE: begin
                    r_ack <= 1'b0;
                    r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Request fields are captured once at accept; later input changes are ignored.
    always_ff @(posedge i_clk) begin
        if (r_state == IDLE && bus.req) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_be    <= bus.be;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_access && r_we && !w_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign bus.stall = (r_state == IDLE && bus.req) || (r_state == BUSY);
endmodule

// File: doc/dmem_wait_resp.md
Name: dmem_wait_resp

Overview:
- Multi-cycle data-memory responder that sits on the far side of the pipeline MEM-stage data port.
- The pipeline issues a load or store request. This block accepts it, holds the pipeline with stall for a fixed access latency, then performs the access and returns read data with a one-cycle ack.
- It replaces the single-cycle data memory so that slow-memory timing can be exercised in the pipelined CPU.

Parameters:
- DEPTH, 64, number of 32-bit words in the array; word index = addr[31:2].
- LATENCY, 2, number of BUSY cycles between accept and completion; legal range 1..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears control state
- req  input  1  request valid from MEM stage; held stable until ack
- we  input  1  1 = store, 0 = load
- addr  input  32  byte address (ALU result)
- wdata  input  32  store data
- be  input  4  byte enables for stores; bit i covers wdata[8i+7:8i]; ignored for loads
- rdata  output  32  load data, registered; valid when ack=1, held until next ack
- ack  output  1  one-cycle completion pulse
- err  output  1  qualifies ack: access was misaligned or out of range
- stall  output  1  freeze request to the pipeline (IF/ID/EX/MEM registers hold)

Behaviour:
- Reset (async, immediate):
  - state=IDLE, counter=0, ack=0, err=0, rdata=0.
  - Memory array contents are not cleared.
  - A request in flight when reset asserts is dropped; no write occurs unless its completion edge already passed.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If req=1 at the edge: latch we, addr, wdata, be; load counter=LATENCY-1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If counter≠0: decrement and stay in BUSY.
  - If counter=0 at the edge: perform the access and go to DONE.
- Access checks, performed at that edge:
  - misaligned = latched addr[1:0]≠0.
  - oob = latched addr[31:2] ≥ DEPTH.
  - If misaligned or oob: no write; rdata←0; err←1.
  - Else store: for each i with be[i]=1, mem[idx][8i+7:8i]←wdata[8i+7:8i]. rdata←0; err←0.
  - Else load: rdata←mem[idx]; err←0.
- DONE:
  - ack=1 for exactly this cycle.
  - At the edge, go unconditionally to IDLE; ack and err clear to 0, rdata holds.
  - req seen during DONE is never accepted, because the pipeline is still presenting the completing request.
- stall (combinational) = (state==IDLE && req) || state==BUSY.
  - stall=0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Latency: req first high in cycle 0 gives ack in cycle LATENCY+1 and stall high in cycles 0..LATENCY. Back-to-back requests therefore complete every LATENCY+2 cycles.
- Latched request fields are used for the access. Input changes after accept have no effect.
- Store with be=0000 completes normally with ack=1, err=0, and memory unchanged.
- Counter width is 4 bits; counter is unused in IDLE and DONE.

Test Plan:
- Reset mid-access:
  - Store addr=0x10, wdata=0xDEADBEEF, be=1111; assert reset in first BUSY cycle.
  - Required: ack never pulses, stall drops immediately, later load of 0x10 does not return 0xDEADBEEF (preload it with 0x11111111 first and check that value is returned).
- Store/load timing, LATENCY=2:
  - Store 0xCAFEF00D to addr 0x08; then load 0x08.
  - Required: ack in cycle 3 of each request, stall high cycles 0–2, rdata=0xCAFEF00D, err=0.
- Byte enables:
  - Store 0xFFFFFFFF be=1111 to 0x04, then store 0x12345678 be=0101 to 0x04, then load 0x04.
  - Required: rdata=0xFF34FF78.
- Errors:
  - Load addr=0x06 -> ack with err=1, rdata=0.
  - Store addr=0x100 with DEPTH=64 -> ack with err=1; load 0x00 unchanged.
- Back-to-back and input changes:
  - req held high across two consecutive loads.
  - Required: acks exactly LATENCY+2 cycles apart; changing addr during BUSY does not alter the returned data.
- LATENCY=1 instance:
  - A load acks in cycle 2, with stall high in cycles 0–1 only.
